multdiv_sequencer: RTL

Execute-stage controller that sequences the shared multiply/divide unit for the 5-stage pipeline. Accepts one mult/div request at a time from DX, latches the operands, issues a single-cycle start pulse, and holds the pipeline stalled until the unit reports ready. It then delivers the result, substituting the $rstatus code and redirecting the destination to r30 on exception. Also supports flush (squash) and bounds runaway operations with a watchdog.

---
 rtl/multdiv_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: execute-stage controller for the shared mult/div unit.
// It latches one request, pulses start, stalls until ready, then delivers the
// result. An exception or a watchdog timeout turns the result into a
// $rstatus code that is written to r30.
module multdiv_sequencer #(
  parameter int TIMEOUT  = 64,
  parameter int EXC_MULT = 4,
  parameter int EXC_DIV  = 5,
  parameter int RSTATUS  = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        md_ctrl_MULT_o,
  output logic        md_ctrl_DIV_o,
  output logic [31:0] md_operandA_o,
  output logic [31:0] md_operandB_o,
  input  logic [31:0] md_result_i,
  input  logic        md_exception_i,
  input  logic        md_resultRDY_i,
  output logic        stall_o,
  output logic        res_valid_o,
  output logic [31:0] res_data_o,
  output logic [4:0]  res_rd_o,
  output logic        res_exc_o,
  output logic        err_timeout_o
);

  localparam int WDW = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            op_q;
  logic [31:0]     a_q, b_q;
  logic [4:0]      rd_q;
  logic [31:0]     res_data_q;
  logic [4:0]      res_rd_q;
  logic            res_exc_q;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q;

  logic accept, capture, cap_fault, wd_inc, err_set, wd_hit, fault;

  // Next-state and per-state outputs.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    capture        = 1'b0;
    cap_fault      = 1'b0;
    wd_inc         = 1'b0;
    err_set        = 1'b0;
    md_ctrl_MULT_o = 1'b0;
    md_ctrl_DIV_o  = 1'b0;
    stall_o        = 1'b0;
    res_valid_o    = 1'b0;
    // This is the TIMEOUT-th BUSY/DRAIN cycle. '>=' also covers a saturated
    // count carried into DRAIN.
    wd_hit         = (wd_q >= WD_LAST);
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        md_ctrl_MULT_o = ~op_q;
        md_ctrl_DIV_o  = op_q;
        stall_o        = 1'b1;
        state_d        = flush_i ? S_DRAIN : S_BUSY;
      end
      S_BUSY: begin
        stall_o = 1'b1;
        wd_inc  = 1'b1;
        if (flush_i) begin
          // A result that arrives in the same cycle as flush is dropped.
          state_d = md_resultRDY_i ? S_IDLE : S_DRAIN;
        end else if (md_resultRDY_i) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (wd_hit) begin
          capture   = 1'b1;
          cap_fault = 1'b1;
          err_set   = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DRAIN: begin
        stall_o = req_valid_i;
        wd_inc  = 1'b1;
        if (md_resultRDY_i) begin
          state_d = S_IDLE;
        end else if (wd_hit) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        res_valid_o = ~flush_i;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fault = cap_fault | md_exception_i;

  // Watchdog: cleared when a request is accepted, counts BUSY/DRAIN cycles,
  // and saturates.
  always_comb begin
    wd_d = wd_q;
    if (accept)                       wd_d = '0;
    else if (wd_inc && wd_q != WD_MAX) wd_d = wd_q + 1'b1;
  end

  // State, latched request, captured result and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_exc_q  <= 1'b0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (accept) begin
        op_q <= req_op_i;
        a_q  <= req_a_i;
        b_q  <= req_b_i;
        rd_q <= req_rd_i;
      end
      if (capture) begin
        res_data_q <= fault ? (op_q ? 32'(EXC_DIV) : 32'(EXC_MULT)) : md_result_i;
        res_rd_q   <= fault ? 5'(RSTATUS) : rd_q;
        res_exc_q  <= fault;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign md_operandA_o = a_q;
  assign md_operandB_o = b_q;
  assign res_data_o    = res_data_q;
  assign res_rd_o      = res_rd_q;
  assign res_exc_o     = res_exc_q;
  assign err_timeout_o = err_q;

endmodule
